// File: rtl/vedic_mac_accumulator.sv
// ----------------------------------------------------------------------------
// vedic_mac_accumulator
//
// Sequential MAC stage behind the combinational 16x16 Vedic multiplier.
// A job starts with a one-cycle start pulse carrying a beat count (len).
// The block then accepts len unsigned products over a valid/ready input port
// and sums them into a saturating ACC_W-bit accumulator. The result is
// offered on a valid/ready output port.
//
// State table:
//   state   | meaning
//   S_IDLE  | waiting for start; last result/overflow remain visible
//   S_ACCUM | accepting product beats (in_ready=1) until remaining hits 0
//   S_HOLD  | result offered (out_valid=1) until out_ready
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_start      one-cycle job start pulse (honoured only in S_IDLE)
//   i_len        beats to accumulate, sampled on accepted start
//   i_prod       unsigned product from the multiplier
//   i_in_valid   i_prod valid this cycle
//   o_in_ready   block accepts i_prod this cycle
//   o_acc_out    accumulated result
//   o_out_valid  o_acc_out holds a completed result
//   i_out_ready  downstream takes the result
//   o_busy       high in S_ACCUM or S_HOLD
//   o_overflow   sticky saturation flag for the current/last result
// ----------------------------------------------------------------------------
module vedic_mac_accumulator #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [PROD_W-1:0] i_prod,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic [ACC_W-1:0]  o_acc_out,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_busy,
    output logic              o_overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [LEN_W-1:0]   r_remaining;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_overflow;

    logic [ACC_W:0]     w_sum;
    logic               w_beat;

    // One extra bit so the carry-out flags saturation.
    assign w_sum  = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_prod};
    assign w_beat = i_in_valid && r_in_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_remaining <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_acc       <= '0;
                        r_overflow  <= 1'b0;
                        r_remaining <= i_len;
                        r_busy      <= 1'b1;
                        if (i_len == '0) begin
                            // Empty job: present a zero result immediately.
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state    <= S_ACCUM;
                            r_in_ready <= 1'b1;
                        end
                    end
                end

                S_ACCUM: begin
                    if (w_beat) begin
                        if (w_sum[ACC_W]) begin
                            r_acc      <= '1;
                            r_overflow <= 1'b1;
                        end else begin
                            r_acc <= w_sum[ACC_W-1:0];
                        end
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (r_remaining == LEN_W'(1)) begin
                            // Final beat: result is valid on this same edge.
                            r_state     <= S_HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end

                S_HOLD: begin
                    if (i_out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_acc_out   = r_acc;
    assign o_out_valid = r_out_valid;
    assign o_busy      = r_busy;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_vedic_mac_accumulator.sv
// ----------------------------------------------------------------------------
// Testbench for vedic_mac_accumulator. Inputs are driven and outputs sampled
// on the falling clock edge. Expected sums come from a plain integer model:
// add each product, clamp to 2^40-1 and latch overflow on clamp.
// ----------------------------------------------------------------------------
module tb_vedic_mac_accumulator;

    localparam int    PROD_W  = 32;
    localparam int    ACC_W   = 40;
    localparam int    LEN_W   = 16;
    localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic [PROD_W-1:0] prod;
    logic              in_valid;
    logic              in_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    logic [PROD_W-1:0] pq[$];

    vedic_mac_accumulator #(
        .PROD_W(PROD_W),
        .ACC_W (ACC_W),
        .LEN_W (LEN_W)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_len      (len),
        .i_prod     (prod),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .o_acc_out  (acc_out),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_busy     (busy),
        .o_overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_acc(input string name, input logic [ACC_W-1:0] act, input longint exp);
        logic [ACC_W-1:0] e;
        e = exp[ACC_W-1:0];
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: acc_out got %0d expected %0d at %0t", name, act, e, $time);
        end
    endtask

    // gap_mode: 0 = valid always high, 1 = toggle 1,0,1,..., 2 = random.
    // pulse_at: loop cycle at which a stray start (len=5) is pulsed, -1 = none.
    task automatic run_job(input string name, input int n, input int gap_mode,
                           input int hold_cycles, input int pulse_at);
        longint exp_sum = 0;
        logic   exp_ovf = 1'b0;
        int     k = 0;
        int     cyc = 0;
        logic   beat;
        @(negedge clk);
        start = 1'b1;
        len   = LEN_W'(n);
        @(negedge clk);
        start = 1'b0;
        len   = '0;
        chk_bit({name, " busy_after_start"}, busy, 1'b1);
        chk_acc({name, " acc_cleared"}, acc_out, 0);
        chk_bit({name, " ovf_cleared"}, overflow, 1'b0);
        chk_bit({name, " out_valid_after_start"}, out_valid, (n == 0));
        chk_bit({name, " in_ready_after_start"}, in_ready, (n != 0));
        while (k < n && cyc < 4 * n + 20) begin
            case (gap_mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            prod  = pq[k];
            start = (cyc == pulse_at);
            len   = (cyc == pulse_at) ? LEN_W'(5) : '0;
            beat  = in_valid && in_ready;
            @(negedge clk);
            start = 1'b0;
            len   = '0;
            if (beat) begin
                exp_sum = exp_sum + longint'(pq[k]);
                if (exp_sum > ACC_MAX) begin
                    exp_sum = ACC_MAX;
                    exp_ovf = 1'b1;
                end
                k++;
                chk_acc({name, " running_sum"}, acc_out, exp_sum);
                chk_bit({name, " running_ovf"}, overflow, exp_ovf);
                chk_bit({name, " out_valid_timing"}, out_valid, (k == n));
                chk_bit({name, " in_ready_timing"}, in_ready, (k != n));
            end
            cyc++;
        end
        in_valid = 1'b0;
        if (k < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: accepted %0d beats expected %0d", name, k, n);
        end
        // Back-pressure: extra valid beats offered while the result is held.
        for (int h = 0; h < hold_cycles; h++) begin
            in_valid  = 1'b1;
            prod      = $urandom;
            out_ready = 1'b0;
            @(negedge clk);
            chk_bit({name, " hold_out_valid"}, out_valid, 1'b1);
            chk_bit({name, " hold_in_ready"}, in_ready, 1'b0);
            chk_acc({name, " hold_acc"}, acc_out, exp_sum);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk_bit({name, " out_valid_drop"}, out_valid, 1'b0);
        chk_bit({name, " busy_drop"}, busy, 1'b0);
        chk_acc({name, " idle_acc_kept"}, acc_out, exp_sum);
        chk_bit({name, " idle_ovf_kept"}, overflow, exp_ovf);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_acc("reset acc", acc_out, 0);
        chk_bit("reset in_ready", in_ready, 1'b0);
        chk_bit("reset out_valid", out_valid, 1'b0);
        chk_bit("reset busy", busy, 1'b0);
        chk_bit("reset overflow", overflow, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        pq = '{32'd16261, 32'd335850, 32'd589743};
        run_job("basic", 3, 0, 2, -1);
        chk_acc("basic literal", acc_out, 941854);
    endtask

    task automatic test_gapped();
        pq = '{32'd16261, 32'd335850, 32'd589743};
        run_job("gapped", 3, 1, 3, -1);
        chk_acc("gapped literal", acc_out, 941854);
    endtask

    task automatic test_len_zero();
        pq.delete();
        run_job("len0", 0, 0, 5, -1);
        chk_acc("len0 literal", acc_out, 0);
    endtask

    task automatic test_overflow();
        pq.delete();
        for (int i = 0; i < 257; i++) pq.push_back(32'hFFFE_0001);
        run_job("overflow", 257, 0, 1, -1);
        chk_acc("overflow literal", acc_out, 64'hFF_FFFF_FFFF);
        chk_bit("overflow literal flag", overflow, 1'b1);
        pq = '{32'd7};
        run_job("after_overflow", 1, 0, 0, -1);
    endtask

    task automatic test_start_ignored();
        pq = '{32'd1000, 32'd234};
        run_job("start_in_accum", 2, 0, 1, 0);
        chk_acc("start_in_accum literal", acc_out, 1234);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1;
        len   = LEN_W'(3);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        prod     = 32'd12345;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_acc("async_reset acc", acc_out, 0);
        chk_bit("async_reset busy", busy, 1'b0);
        chk_bit("async_reset in_ready", in_ready, 1'b0);
        chk_bit("async_reset out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        pq = '{32'd5};
        run_job("after_reset", 1, 0, 0, -1);
        chk_acc("after_reset literal", acc_out, 5);
    endtask

    task automatic test_random();
        int n;
        for (int j = 0; j < 6; j++) begin
            n = $urandom_range(1, 20);
            pq.delete();
            for (int i = 0; i < n; i++) pq.push_back($urandom);
            run_job("random", n, 2, $urandom_range(0, 3), -1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        prod      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_gapped();
        test_len_zero();
        test_overflow();
        test_start_ignored();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
